cop0_irq: RTL and testbench

Parametrised MIPS coprocessor-0 register file with a Count/Compare timer, configurable external interrupt lines, ERET handling and nested-exception EPC protection. It sits beside the execute/writeback stage. It serves MFC0/MTC0 traffic, records exception state from the exception unit, and raises a single interrupt request to the pipeline's exception logic.

---
 rtl/cop0_irq.sv | 120 ++++++++++++
 tb/tb_cop0_irq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cop0_irq.sv
// cop0_irq: MIPS coprocessor-0 register file with Count/Compare timer, external interrupts, ERET and nested-exception EPC protection
module cop0_irq #(
    parameter int HW_IRQ      = 6,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        raddr,
    output logic [31:0]       rdata,
    input  logic              wen,
    input  logic [7:0]        waddr,
    input  logic [31:0]       wdata,
    input  logic [HW_IRQ-1:0] hw_int,
    input  logic              exp_en,
    input  logic              exp_badvaddr_en,
    input  logic [31:0]       exp_badvaddr,
    input  logic              exp_bd,
    input  logic [4:0]        exp_code,
    input  logic [31:0]       exp_epc,
    input  logic              eret,
    output logic [31:0]       epc_address,
    output logic              int_pending,
    output logic              status_exl
);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58,
                           A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

    logic [PW-1:0]                     presc_q, presc_d;
    logic [31:0]                       count_q, count_d, compare_q, compare_d;
    logic [31:0]                       epc_q, epc_d, badv_q, badv_d;
    logic [7:0]                        im_q, im_d;
    logic                              ie_q, ie_d, exl_q, exl_d, bd_q, bd_d, ti_q, ti_d;
    logic [4:0]                        exc_q, exc_d;
    logic [1:0]                        ip_sw_q, ip_sw_d;
    logic [5:0]                        ip_hw_q, ip_hw_d;
    logic [SYNC_STAGES-1:0][HW_IRQ-1:0] sync_q, sync_d;
    logic [7:0]                        ip;
    logic                              tick, wr_count, wr_compare, wr_status, wr_cause, wr_epc, first_exc;

    // Next-state logic: timer, exception bookkeeping (exp_en > eret > MTC0) and interrupt synchronisers
    always_comb begin
        wr_count   = wen & (waddr == A_COUNT);
        wr_compare = wen & (waddr == A_COMPARE);
        wr_status  = wen & (waddr == A_STATUS);
        wr_cause   = wen & (waddr == A_CAUSE);
        wr_epc     = wen & (waddr == A_EPC);
        tick       = presc_q == PW'(COUNT_DIV - 1);
        first_exc  = exp_en & ~exl_q;
        presc_d    = (wr_count | tick) ? '0 : presc_q + 1'b1;
        count_d    = wr_count ? wdata : tick ? count_q + 32'd1 : count_q;
        compare_d  = wr_compare ? wdata : compare_q;
        ti_d       = wr_compare ? 1'b0 : (tick & ~wr_count & (count_q + 32'd1 == compare_q)) ? 1'b1 : ti_q;
        im_d       = wr_status ? wdata[15:8] : im_q;
        ie_d       = wr_status ? wdata[0] : ie_q;
        exl_d      = exp_en ? 1'b1 : eret ? 1'b0 : wr_status ? wdata[1] : exl_q;
        epc_d      = first_exc ? exp_epc : wr_epc ? wdata : epc_q;
        bd_d       = first_exc ? exp_bd : bd_q;
        exc_d      = exp_en ? exp_code : exc_q;
        badv_d     = (exp_en & exp_badvaddr_en) ? exp_badvaddr : badv_q;
        ip_sw_d    = wr_cause ? wdata[9:8] : ip_sw_q;
        sync_d[0]  = hw_int;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        ip_hw_d    = '0;
        ip_hw_d[HW_IRQ-1:0] = sync_q[SYNC_STAGES-1];
    end

    // State registers; reset wins over every strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
            im_q      <= '0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            exc_q     <= '0;
            ip_sw_q   <= '0;
            ip_hw_q   <= '0;
            sync_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            exc_q     <= exc_d;
            ip_sw_q   <= ip_sw_d;
            ip_hw_q   <= ip_hw_d;
            sync_q    <= sync_d;
        end
    end

    // Read mux and interrupt request, purely from current state
    always_comb begin
        ip          = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
        int_pending = ie_q & ~exl_q & |(ip & im_q);
        status_exl  = exl_q;
        epc_address = epc_q;
        case (raddr)
            A_BADV:    rdata = badv_q;
            A_COUNT:   rdata = count_q;
            A_COMPARE: rdata = compare_q;
            A_STATUS:  rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            A_CAUSE:   rdata = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_q, 2'b0};
            A_EPC:     rdata = epc_q;
            default:   rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_cop0_irq.sv
// tb_cop0_irq: directed self-checking bench for cop0_irq
module tb_cop0_irq;
    logic        clk = 1'b0, rst, wen, exp_en, exp_badvaddr_en, exp_bd, eret;
    logic [7:0]  raddr, waddr;
    logic [31:0] rdata, wdata, exp_badvaddr, exp_epc, epc_address;
    logic [5:0]  hw_int;
    logic [4:0]  exp_code;
    logic        int_pending, status_exl;
    int          tests = 0, fails = 0;

    localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58,
                           A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70, A_NONE = 8'h78;

    cop0_irq #(.HW_IRQ(6), .COUNT_DIV(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata),
        .hw_int(hw_int), .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_badvaddr(exp_badvaddr),
        .exp_bd(exp_bd), .exp_code(exp_code), .exp_epc(exp_epc), .eret(eret),
        .epc_address(epc_address), .int_pending(int_pending), .status_exl(status_exl)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 0; waddr = 0; wdata = 0; raddr = 0; hw_int = 0;
        exp_en = 0; exp_badvaddr_en = 0; exp_badvaddr = 0; exp_bd = 0; exp_code = 0; exp_epc = 0; eret = 0;
        tick(2);
        rst = 1'b0;
        rd("reset_status", A_STATUS, 32'h0040_0000);
        rd("reset_cause", A_CAUSE, 32'h0);
        rd("unimpl_15", A_NONE, 32'h0);
        chk("reset_int_pending", int_pending, 0);
        chk("reset_exl", status_exl, 0);
        chk("reset_epc", epc_address, 0);
        tick(10);
        rd("count_after_10", A_COUNT, 32'd5);

        mtc0(A_COMPARE, 32'd8);
        mtc0(A_COUNT, 32'd5);
        tick(5);
        rd("count_7", A_COUNT, 32'd7);
        rd("ti_not_yet", A_CAUSE, 32'h0);
        tick();
        rd("count_8", A_COUNT, 32'd8);
        rd("ti_set", A_CAUSE, 32'h4000_8000);
        chk("ip_masked", int_pending, 0);

        mtc0(A_STATUS, 32'h0000_8001);
        rd("status_rw", A_STATUS, 32'h0040_8001);
        chk("timer_irq", int_pending, 1);

        exp_en = 1; exp_code = 0; exp_epc = 32'h80; exp_badvaddr_en = 1; exp_badvaddr = 32'hdead_beef;
        tick();
        exp_en = 0; exp_badvaddr_en = 0;
        chk("exc_exl", status_exl, 1);
        chk("exc_masks_irq", int_pending, 0);
        chk("exc_epc", epc_address, 32'h80);
        rd("exc_badvaddr", A_BADV, 32'hdead_beef);
        eret = 1;
        tick();
        eret = 0;
        chk("eret_exl", status_exl, 0);
        chk("eret_irq", int_pending, 1);

        mtc0(A_COMPARE, 32'd20);
        rd("compare_clears_ti", A_CAUSE, 32'h0);
        chk("ti_clear_irq", int_pending, 0);
        mtc0(A_COMPARE, 32'hFFFF_0000);

        exp_en = 1; exp_epc = 32'h100; exp_bd = 1; exp_code = 5'd2;
        tick();
        exp_epc = 32'h200; exp_bd = 0; exp_code = 5'd4;
        tick();
        exp_en = 0;
        chk("nested_epc", epc_address, 32'h100);
        rd("nested_cause", A_CAUSE, 32'h8000_0010);
        eret = 1;
        tick();
        eret = 0;

        mtc0(A_STATUS, 32'h0000_1001);
        hw_int[2] = 1'b1;
        tick(2);
        chk("hw_rise_early", int_pending, 0);
        tick();
        chk("hw_rise", int_pending, 1);
        rd("hw_cause", A_CAUSE, 32'h8000_1010);
        hw_int[2] = 1'b0;
        tick(2);
        chk("hw_fall_early", int_pending, 1);
        tick();
        chk("hw_fall", int_pending, 0);

        mtc0(A_CAUSE, 32'h0000_0300);
        rd("sw_ip", A_CAUSE, 32'h8000_0310);
        mtc0(A_STATUS, 32'h0000_0101);
        chk("sw_irq", int_pending, 1);
        mtc0(A_CAUSE, 32'h0);
        chk("sw_irq_clear", int_pending, 0);

        mtc0(A_COMPARE, 32'h0);
        mtc0(A_COUNT, 32'hFFFF_FFFF);
        tick();
        rd("count_max", A_COUNT, 32'hFFFF_FFFF);
        tick();
        rd("count_wrap", A_COUNT, 32'h0);
        rd("wrap_ti", A_CAUSE, 32'hC000_8010);

        wen = 1; waddr = A_EPC; wdata = 32'h44;
        exp_en = 1; exp_epc = 32'h88; exp_bd = 0; exp_code = 0;
        tick();
        wen = 0; exp_en = 0;
        chk("same_edge_epc", epc_address, 32'h88);
        chk("same_edge_exl", status_exl, 1);

        wen = 1; waddr = A_STATUS; wdata = 32'h3; eret = 1;
        tick();
        wen = 0; eret = 0;
        rd("eret_beats_mtc0", A_STATUS, 32'h0040_0001);

        wen = 1; waddr = A_EPC; wdata = 32'h44;
        rd("read_old_on_write", A_EPC, 32'h88);
        tick();
        wen = 0;
        chk("epc_mtc0", epc_address, 32'h44);

        rst = 1; wen = 1; waddr = A_COUNT; wdata = 32'h1234;
        tick();
        rst = 0; wen = 0;
        rd("rst_beats_wen", A_COUNT, 32'h0);
        chk("rst_epc", epc_address, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
